midi_parser: RTL and testbench
==============================

# midi_parser

Converts a serial stream of received MIDI bytes into the 16-bit note word consumed by the signal pipeline (bit 15 zero, bits 14:8 MIDI note, bits 7:0 velocity; all-zero means silence). It sits between the UART byte receiver and the pipeline. It decodes channel voice messages for one configured channel, supports running status and ignores interleaved realtime bytes. It is monophonic with last-note priority.

## Interface
- CHANNEL, 0, MIDI channel (0–15) whose messages are decoded; all other channels are parsed for framing and discarded.
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_byte  input  8  received MIDI byte.
- i_byte_valid  input  1  single-cycle qualifier; i_byte is consumed on every rising edge where this is high.
- o_data  output  16  registered note word {1'b0, note[6:0], vel[7:0]}; held until changed; 16'h0000 = no note.
- o_strobe  output  1  one-cycle pulse on the edge where o_data is written (including writes to zero).

## Operation
- Byte classes: realtime (8'hF8–8'hFF), system (8'hF0–8'hF7), channel status (8'h80–8'hEF), data (bit 7 = 0).
- Realtime bytes are ignored completely: no state, count or running-status change.
- System bytes clear running status and set the state to IDLE. Data bytes that follow are dropped, which covers SysEx payloads.
- A channel status byte always aborts any partial message. It latches the status nibble and channel as running status and enters WAIT_D1.
- Data-byte count comes from the status nibble:
  - 1 byte for 4'hC (program change) and 4'hD (channel pressure).
  - 2 bytes for 4'h8, 9, A, B and E.
- States:
  - IDLE: no running status; data bytes are dropped.
  - WAIT_D1: the next data byte is latched as d1.
    - For a 1-byte message, it completes the message and the state returns to WAIT_D1 (running status).
    - Otherwise go to WAIT_D2.
  - WAIT_D2: the next data byte is d2 and completes the message; return to WAIT_D1.
- Actions on completion, taken only when the latched channel equals CHANNEL:
  - Note-on (4'h9) with d2 ≠ 0: o_data ← {1'b0, d1, 1'b0, d2}, o_strobe = 1. This replaces any sounding note.
  - Note-on with d2 = 0, or note-off (4'h8): if d1 equals o_data[14:8] and o_data ≠ 0, then o_data ← 0 and o_strobe = 1. Otherwise no change and no strobe.
  - Control change (4'hB) with d1 = 7'd123 (all notes off): o_data ← 0 and o_strobe = 1, even if o_data is already zero.
  - All other messages: no output change.
- Velocity is the 7-bit data value zero-extended to 8 bits. Note 0 with non-zero velocity is a valid, non-zero word.
- Reset:
  - o_data = 16'h0000, o_strobe = 0.
  - State IDLE, running status cleared, d1 cleared.
  - If asserted mid-message, the partial message is discarded. The first data byte after reset is dropped.

## Timing
- Latency is one edge. o_data and o_strobe update on the same rising edge that samples the completing byte with i_byte_valid = 1.
- o_strobe is high for exactly one cycle per write. It is low on every edge where i_byte_valid = 0.
- Back-to-back bytes (i_byte_valid high on every cycle) are fully supported, with no throughput limit.
- A realtime byte between d1 and d2 delays completion by one accepted byte only. d1 is preserved.

## Structure
- Shared include midi_defs.vh holds:
  - status nibble constants (NOTE_OFF 4'h8, NOTE_ON 4'h9, POLY_AT 4'hA, CC 4'hB, PROG 4'hC, CHAN_AT 4'hD, PITCH 4'hE);
  - CC_ALL_NOTES_OFF 7'd123;
  - realtime threshold 8'hF8;
  - state encodings IDLE / WAIT_D1 / WAIT_D2.
- No sub-module. The byte classifier is combinational logic inside the block.

## Test plan
- 90 3C 64 → o_data = 16'h3C64 with one o_strobe. Then 80 3C 00 → o_data = 16'h0000 with one strobe.
- Running status: 90 3C 64 40 50 → o_data = 16'h3C64, then 16'h4050. Then 3C 00 → no change, no strobe (note mismatch). Then 40 00 → 16'h0000.
- Realtime interleave: 90 F8 3C FE 64 → o_data = 16'h3C64 on the edge sampling 64. F8 and FE produce no strobe.
- Channel filter with CHANNEL = 0: 91 3C 64 → o_data stays 0. C0 05 then 3C 64 → no change; running status is program change, so 3C and 64 are each a 1-byte message. 90 3C 64 then B0 7B 00 → 16'h0000.
- System abort: 90 3C F0 7F 7F F7 64 → o_data stays 0 and no strobe.
- Async reset asserted between 90 3C and 64 → o_data = 0 immediately. The following 64 is dropped and no strobe is produced.

Source files
------------

// File: rtl/midi_parser_pkg.sv
// midi_parser_pkg: shared MIDI constants, parser state encoding and message-length helper.
`default_nettype none

package midi_parser_pkg;

    localparam logic [3:0] NOTE_OFF = 4'h8;
    localparam logic [3:0] NOTE_ON  = 4'h9;
    localparam logic [3:0] POLY_AT  = 4'hA;
    localparam logic [3:0] CC       = 4'hB;
    localparam logic [3:0] PROG     = 4'hC;
    localparam logic [3:0] CHAN_AT  = 4'hD;
    localparam logic [3:0] PITCH    = 4'hE;

    localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;
    localparam logic [7:0] RT_THRESHOLD     = 8'hF8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_D1 = 2'd1,
        WAIT_D2 = 2'd2
    } state_e;

    // Program change and channel pressure carry a single data byte.
    function automatic logic is_one_byte_msg(input logic [3:0] nibble);
        return (nibble == PROG) || (nibble == CHAN_AT);
    endfunction

endpackage

`default_nettype wire

// File: rtl/midi_parser.sv
// midi_parser: MIDI byte stream to monophonic 16-bit note word, last-note priority,
// running status and realtime-byte transparency.
`default_nettype none

module midi_parser
    import midi_parser_pkg::*;
#(
    parameter int unsigned CHANNEL = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  i_byte,
    input  logic        i_byte_valid,
    output logic [15:0] o_data,
    output logic        o_strobe
);

    localparam logic [3:0] C_CHAN = 4'(CHANNEL);

    state_e      state_q;
    logic [3:0]  status_q;
    logic [3:0]  chan_q;
    logic [6:0]  d1_q;
    logic [15:0] data_q;
    logic        strobe_q;

    logic        byte_is_rt;
    logic        byte_is_sys;
    logic        byte_is_status;
    logic        byte_is_data;
    logic        msg_done;
    logic [6:0]  msg_d1;
    logic [6:0]  msg_d2;
    logic [15:0] data_d;
    logic        strobe_d;

    always_comb begin
        byte_is_rt     = (i_byte >= RT_THRESHOLD);
        byte_is_sys    = (i_byte[7:4] == 4'hF) && !byte_is_rt;
        byte_is_status = i_byte[7] && (i_byte[7:4] != 4'hF);
        byte_is_data   = !i_byte[7];
    end

    // A message completes on the data byte that satisfies the running-status length.
    always_comb begin
        msg_done = i_byte_valid && byte_is_data &&
                   ((state_q == WAIT_D2) ||
                    ((state_q == WAIT_D1) && is_one_byte_msg(status_q)));
        msg_d1   = (state_q == WAIT_D2) ? d1_q : i_byte[6:0];
        msg_d2   = (state_q == WAIT_D2) ? i_byte[6:0] : 7'd0;
    end

    always_comb begin
        data_d   = data_q;
        strobe_d = 1'b0;
        if (msg_done && (chan_q == C_CHAN)) begin
            case (status_q)
                NOTE_ON: begin
                    if (msg_d2 != 7'd0) begin
                        data_d   = {1'b0, msg_d1, 1'b0, msg_d2};
                        strobe_d = 1'b1;
                    end else if ((data_q != 16'h0000) && (data_q[14:8] == msg_d1)) begin
                        data_d   = 16'h0000;
                        strobe_d = 1'b1;
                    end
                end
                NOTE_OFF: begin
                    if ((data_q != 16'h0000) && (data_q[14:8] == msg_d1)) begin
                        data_d   = 16'h0000;
                        strobe_d = 1'b1;
                    end
                end
                CC: begin
                    if (msg_d1 == CC_ALL_NOTES_OFF) begin
                        data_d   = 16'h0000;
                        strobe_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            status_q <= 4'h0;
            chan_q   <= 4'h0;
            d1_q     <= 7'd0;
            data_q   <= 16'h0000;
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= strobe_d;
            data_q   <= data_d;
            if (i_byte_valid) begin
                if (byte_is_status) begin
                    status_q <= i_byte[7:4];
                    chan_q   <= i_byte[3:0];
                    state_q  <= WAIT_D1;
                end else if (byte_is_sys) begin
                    status_q <= 4'h0;
                    chan_q   <= 4'h0;
                    state_q  <= IDLE;
                end else if (byte_is_data) begin
                    case (state_q)
                        WAIT_D1: begin
                            d1_q <= i_byte[6:0];
                            if (!is_one_byte_msg(status_q)) begin
                                state_q <= WAIT_D2;
                            end
                        end
                        WAIT_D2: state_q <= WAIT_D1;
                        default: state_q <= IDLE;
                    endcase
                end
            end
        end
    end

    assign o_data   = data_q;
    assign o_strobe = strobe_q;

endmodule

`default_nettype wire

// File: tb/tb_midi_parser.sv
// tb_midi_parser: directed test-plan sequences plus randomized byte streams checked
// against a queue-based MIDI message model.
`default_nettype none

module tb_midi_parser;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  i_byte = 8'h00;
    logic        i_byte_valid = 1'b0;
    logic [15:0] o_data;
    logic        o_strobe;

    int tests = 0;
    int fails = 0;

    // Reference model: running status as a whole byte (-1 = none) plus pending data bytes.
    int          m_rs = -1;
    int          m_pend[$];
    logic [15:0] m_data = 16'h0000;
    logic        m_strobe = 1'b0;

    midi_parser #(.CHANNEL(0)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_byte       (i_byte),
        .i_byte_valid (i_byte_valid),
        .o_data       (o_data),
        .o_strobe     (o_strobe)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_rs = -1;
        m_pend.delete();
        m_data = 16'h0000;
        m_strobe = 1'b0;
    endtask

    task automatic model_finish_msg(input int rs, input int d1, input int d2);
        int nib;
        int ch;
        nib = rs / 16;
        ch  = rs % 16;
        if (ch != 0) return;
        if (nib == 9 && d2 != 0) begin
            m_data = 16'(d1 * 256 + d2);
            m_strobe = 1'b1;
        end else if (nib == 8 || nib == 9) begin
            if (m_data != 16'h0000 && int'(m_data) / 256 == d1) begin
                m_data = 16'h0000;
                m_strobe = 1'b1;
            end
        end else if (nib == 11 && d1 == 123) begin
            m_data = 16'h0000;
            m_strobe = 1'b1;
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        int need;
        m_strobe = 1'b0;
        if (b >= 8'hF8) begin
            return;
        end else if (b >= 8'hF0) begin
            m_rs = -1;
            m_pend.delete();
        end else if (b >= 8'h80) begin
            m_rs = int'(b);
            m_pend.delete();
        end else if (m_rs >= 0) begin
            m_pend.push_back(int'(b));
            need = (m_rs / 16 == 12 || m_rs / 16 == 13) ? 1 : 2;
            if (m_pend.size() == need) begin
                model_finish_msg(m_rs, m_pend[0], (need == 2) ? m_pend[1] : 0);
                m_pend.delete();
            end
        end
    endtask

    task automatic check(input string tag);
        tests++;
        assert (o_data === m_data) else begin
            fails++;
            $error("FAIL %s o_data got %h expected %h", tag, o_data, m_data);
        end
        tests++;
        assert (o_strobe === m_strobe) else begin
            fails++;
            $error("FAIL %s o_strobe got %b expected %b", tag, o_strobe, m_strobe);
        end
    endtask

    task automatic send(input logic [7:0] b, input string tag);
        i_byte = b;
        i_byte_valid = 1'b1;
        @(posedge clk);
        model_byte(b);
        #1;
        i_byte_valid = 1'b0;
        check(tag);
    endtask

    task automatic idle(input int n, input string tag);
        i_byte_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            i_byte = 8'($urandom);
            @(posedge clk);
            m_strobe = 1'b0;
            #1;
            check(tag);
        end
    endtask

    task automatic send_seq(input logic [7:0] seq[$], input string tag);
        foreach (seq[k]) send(seq[k], tag);
    endtask

    initial begin
        logic [7:0] s[$];
        int r;
        logic [7:0] b;
        logic [7:0] notes[4];
        notes[0] = 8'h3C; notes[1] = 8'h40; notes[2] = 8'h00; notes[3] = 8'h45;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check("reset");
        rst = 1'b0;
        idle(2, "post_reset_idle");

        s = '{8'h90, 8'h3C, 8'h64};          send_seq(s, "note_on");
        s = '{8'h80, 8'h3C, 8'h00};          send_seq(s, "note_off");
        s = '{8'h90, 8'h3C, 8'h64, 8'h40, 8'h50}; send_seq(s, "running_status");
        s = '{8'h3C, 8'h00};                 send_seq(s, "rs_mismatch_off");
        s = '{8'h40, 8'h00};                 send_seq(s, "rs_match_off");
        s = '{8'h90, 8'hF8, 8'h3C, 8'hFE, 8'h64}; send_seq(s, "realtime_interleave");
        s = '{8'hB0, 8'h7B, 8'h00};          send_seq(s, "cc_all_off");
        s = '{8'hB0, 8'h7B, 8'h00};          send_seq(s, "cc_all_off_when_zero");
        s = '{8'h91, 8'h3C, 8'h64};          send_seq(s, "other_channel");
        s = '{8'hC0, 8'h05, 8'h3C, 8'h64};   send_seq(s, "program_change_rs");
        s = '{8'h90, 8'h00, 8'h01};          send_seq(s, "note_zero_nonzero_vel");
        s = '{8'h90, 8'h3C, 8'h64, 8'hB0, 8'h7B, 8'h00}; send_seq(s, "cc_clear");
        s = '{8'h90, 8'h3C, 8'hF0, 8'h7F, 8'h7F, 8'hF7, 8'h64}; send_seq(s, "sys_abort");
        s = '{8'h90, 8'h3C, 8'h80, 8'h3C, 8'h00}; send_seq(s, "status_abort");

        // Async reset between d1 and d2 with a note already sounding.
        s = '{8'h90, 8'h45, 8'h7F, 8'h90, 8'h3C}; send_seq(s, "pre_async_reset");
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("async_reset_immediate");
        @(negedge clk);
        rst = 1'b0;
        send(8'h64, "after_reset_dropped");
        send(8'h3C, "after_reset_dropped2");
        idle(1, "after_reset_idle");

        for (int n = 0; n < 1500; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 6) begin
                b = 8'hF8 + 8'($urandom_range(0, 7));
            end else if (r < 9) begin
                b = 8'hF0 + 8'($urandom_range(0, 7));
            end else if (r < 24) begin
                case ($urandom_range(0, 6))
                    0: b = 8'h80;  1: b = 8'h90;  2: b = 8'h90;  3: b = 8'hB0;
                    4: b = 8'hC0;  5: b = 8'hD0;  default: b = 8'hE0;
                endcase
                if ($urandom_range(0, 3) == 0) b[3:0] = 4'($urandom);
                if ($urandom_range(0, 5) == 0) b[7:4] = 4'hA;
            end else begin
                case ($urandom_range(0, 5))
                    0: b = 8'h00;
                    1: b = 8'h7B;
                    2, 3: b = notes[$urandom_range(0, 3)];
                    default: b = 8'($urandom_range(0, 127));
                endcase
            end
            send(b, "random");
            if ($urandom_range(0, 3) == 0) idle(1, "random_gap");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "simulation time limit reached");
    end

endmodule

`default_nettype wire
